// File: rtl/tinynpu_pkg.sv
// rtl/tinynpu_pkg.sv - shared encodings for the TinyNPU host loader and controller
package tinynpu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_X  = 2'd0,
        OP_LOAD_W  = 2'd1,
        OP_RUN_MAC = 2'd2,
        OP_RUN_OUT = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        CS_LD0 = 2'd0,
        CS_MAC = 2'd1,
        CS_LD1 = 2'd2,
        CS_OUT = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LDX     = 3'd1,
        ST_LDW     = 3'd2,
        ST_REQ_MAC = 3'd3,
        ST_REQ_OUT = 3'd4
    } ld_state_e;

endpackage

// File: rtl/Reg.sv
// rtl/Reg.sv - generic enabled register with synchronous active-high clear
module Reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/tinynpu_loader.sv
// rtl/tinynpu_loader.sv - host command/word sequencer driving TinyNPU load strobes and run requests
// Optional trace ports: TINYNPU_LOADER_TRACE_EN
module tinynpu_loader
    import tinynpu_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int DW   = 8,
    parameter int LENW = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic [1:0]              cmd_op,
    input  logic [$clog2(SIZE)-1:0] cmd_sel,
    input  logic [LENW-1:0]         cmd_len,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DW-1:0]           in_data,
    input  logic [1:0]              ctrl_state,
    output logic                    x_load_val,
    output logic                    w_load_val,
    output logic [$clog2(SIZE)-1:0] w_load_sel,
    output logic [DW-1:0]           load_data,
    output logic                    mac_val,
    output logic                    out_val,
`ifdef TINYNPU_LOADER_TRACE_EN
    output logic [2:0]              trace_state,
    output logic [LENW-1:0]         trace_cnt,
`endif
    output logic                    busy
);

    localparam int SW = $clog2(SIZE);

    logic [2:0]      state_q, state_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic [LENW-1:0] len_q;
    logic [SW-1:0]   sel_q;
    logic            cmd_acc, word_hs, loading;

    assign cmd_acc = cmd_val & cmd_rdy;
    assign word_hs = in_val & in_rdy;

    Reg #(.W(3))    u_state (.clk(clk), .rst(rst), .en(1'b1),    .d(state_d), .q(state_q));
    Reg #(.W(LENW)) u_cnt   (.clk(clk), .rst(rst), .en(1'b1),    .d(cnt_d),   .q(cnt_q));
    Reg #(.W(LENW)) u_len   (.clk(clk), .rst(rst), .en(cmd_acc), .d(cmd_len), .q(len_q));
    Reg #(.W(SW))   u_sel   (.clk(clk), .rst(rst), .en(cmd_acc), .d(cmd_sel), .q(sel_q));

    // Strobes are registered one cycle behind the word handshake.
    Reg #(.W(1))  u_xval (.clk(clk), .rst(rst), .en(1'b1),
                          .d(word_hs && state_q == ST_LDX), .q(x_load_val));
    Reg #(.W(1))  u_wval (.clk(clk), .rst(rst), .en(1'b1),
                          .d(word_hs && state_q == ST_LDW), .q(w_load_val));
    Reg #(.W(SW)) u_wsel (.clk(clk), .rst(rst), .en(word_hs && state_q == ST_LDW),
                          .d(sel_q), .q(w_load_sel));
    Reg #(.W(DW)) u_data (.clk(clk), .rst(rst), .en(word_hs), .d(in_data), .q(load_data));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loading = (state_q == ST_LDX) || (state_q == ST_LDW);
        cmd_rdy = !rst && (state_q == ST_IDLE) && (ctrl_state == CS_LD0 || ctrl_state == CS_LD1);
        // A zero-length load never opens the word port.
        in_rdy  = !rst && loading && (len_q != '0);
        mac_val = (state_q == ST_REQ_MAC);
        out_val = (state_q == ST_REQ_OUT);
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    cnt_d = '0;
                    case (cmd_op)
                        OP_LOAD_X:  state_d = ST_LDX;
                        OP_LOAD_W:  state_d = ST_LDW;
                        OP_RUN_MAC: state_d = ST_REQ_MAC;
                        default:    state_d = ST_REQ_OUT;
                    endcase
                end
            end
            ST_LDX, ST_LDW: begin
                if (len_q == '0) begin
                    state_d = ST_IDLE;
                end else if (word_hs) begin
                    cnt_d = cnt_q + LENW'(1);
                    if (cnt_q == len_q - LENW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_REQ_MAC: if (ctrl_state == CS_MAC) state_d = ST_IDLE;
            ST_REQ_OUT: if (ctrl_state == CS_OUT) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

`ifdef TINYNPU_LOADER_TRACE_EN
    assign trace_state = state_q;
    assign trace_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_tinynpu_loader.sv
// tb/tb_tinynpu_loader.sv - randomized and directed check of tinynpu_loader against a transaction model
module tb_tinynpu_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_val, cmd_rdy;
    logic [1:0] cmd_op;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_len;
    logic       in_val, in_rdy;
    logic [7:0] in_data;
    logic [1:0] ctrl_state;
    logic       x_load_val, w_load_val;
    logic [1:0] w_load_sel;
    logic [7:0] load_data;
    logic       mac_val, out_val, busy;
`ifdef TINYNPU_LOADER_TRACE_EN
    logic [2:0] trace_state;
    logic [7:0] trace_cnt;
`endif

    tinynpu_loader #(.SIZE(4), .DW(8), .LENW(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
        .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
        .ctrl_state(ctrl_state),
        .x_load_val(x_load_val), .w_load_val(w_load_val), .w_load_sel(w_load_sel),
        .load_data(load_data), .mac_val(mac_val), .out_val(out_val),
`ifdef TINYNPU_LOADER_TRACE_EN
        .trace_state(trace_state), .trace_cnt(trace_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: what is being serviced, words still owed, and what
    // the registered strobe outputs must show this cycle.
    int   m_job = 0;          // 0 none, 1 X load, 2 W load, 3 MAC request, 4 OUT request
    int   m_left = 0;
    int   m_sel = 0;
    bit   m_x = 0, m_w = 0;
    int   m_data = 0, m_wsel = 0;
    bit   started = 0;

    always @(negedge clk) begin
        bit e_cmd_rdy, e_in_rdy, hs, acc;
        e_cmd_rdy = !rst && m_job == 0 && (ctrl_state == 0 || ctrl_state == 2);
        e_in_rdy  = !rst && (m_job == 1 || m_job == 2) && m_left > 0;
        if (started) begin
            chk("cmd_rdy",    cmd_rdy,    e_cmd_rdy);
            chk("in_rdy",     in_rdy,     e_in_rdy);
            chk("busy",       busy,       m_job != 0);
            chk("mac_val",    mac_val,    m_job == 3);
            chk("out_val",    out_val,    m_job == 4);
            chk("x_load_val", x_load_val, m_x);
            chk("w_load_val", w_load_val, m_w);
            chk("load_data",  load_data,  m_data);
            chk("w_load_sel", w_load_sel, m_wsel);
            chk("mac_out_excl", mac_val & out_val, 0);
        end
        hs  = in_val && e_in_rdy;
        acc = cmd_val && e_cmd_rdy;
        if (rst) begin
            m_job = 0; m_left = 0; m_x = 0; m_w = 0; m_data = 0; m_wsel = 0;
            started = 1;
        end else begin
            m_x = hs && m_job == 1;
            m_w = hs && m_job == 2;
            if (hs) m_data = in_data;
            if (hs && m_job == 2) m_wsel = m_sel;
            case (m_job)
                0: if (acc) begin
                    m_job  = int'(cmd_op) + 1;
                    m_left = cmd_len;
                    m_sel  = cmd_sel;
                end
                1, 2: begin
                    if (hs) m_left--;
                    if (m_left == 0) m_job = 0;
                end
                3: if (ctrl_state == 1) m_job = 0;
                default: if (ctrl_state == 3) m_job = 0;
            endcase
        end
    end

    // Strobe logs used by the hand-computed expectations.
    int x_log[$], x_cyc[$], w_cyc[$], w_sel[$];
    int mac_hi = 0, out_hi = 0;

    always @(negedge clk) begin
        if (x_load_val === 1'b1) begin x_log.push_back(load_data); x_cyc.push_back(cyc); end
        if (w_load_val === 1'b1) begin w_cyc.push_back(cyc); w_sel.push_back(w_load_sel); end
        if (mac_val === 1'b1) mac_hi++;
        if (out_val === 1'b1) out_hi++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int op, input int sel, input int len);
        cmd_val = 1'b1; cmd_op = 2'(op); cmd_sel = 2'(sel); cmd_len = 8'(len);
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic clear_logs;
        x_log.delete(); x_cyc.delete(); w_cyc.delete(); w_sel.delete();
        mac_hi = 0; out_hi = 0;
    endtask

    initial begin
        rst = 1'b1; cmd_val = 0; cmd_op = 0; cmd_sel = 0; cmd_len = 0;
        in_val = 0; in_data = 0; ctrl_state = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_cmd_rdy", cmd_rdy, 1);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_x", x_load_val, 0);

        // LOAD_X of three back-to-back words
        clear_logs();
        tick();
        issue(0, 0, 3);
        in_val = 1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_val = 0; tick(); tick();
        chk("s1_count", x_log.size(), 3);
        if (x_log.size() == 3) begin
            chk("s1_word0", x_log[0], 8'h11);
            chk("s1_word1", x_log[1], 8'h22);
            chk("s1_word2", x_log[2], 8'h33);
            chk("s1_consecutive", x_cyc[2] - x_cyc[0], 2);
        end
        chk("s1_no_w", w_cyc.size(), 0);
        @(negedge clk) chk("s1_idle", busy, 0);

        // LOAD_W sel=2 len=2 with a gap between words
        tick(); clear_logs();
        issue(1, 2, 2);
        in_val = 1; in_data = 8'hA1; tick();
        in_val = 0; tick();
        in_val = 1; in_data = 8'hA2; tick();
        in_val = 0; tick(); tick();
        chk("s2_pulses", w_cyc.size(), 2);
        if (w_cyc.size() == 2) begin
            chk("s2_gap", w_cyc[1] - w_cyc[0], 2);
            chk("s2_sel0", w_sel[0], 2);
            chk("s2_sel1", w_sel[1], 2);
        end

        // RUN_MAC: MAC seen on the fifth request cycle
        clear_logs(); ctrl_state = 0;
        issue(2, 0, 0);
        repeat (4) tick();
        ctrl_state = 1; tick();
        cmd_val = 1; cmd_op = 2'd2;
        @(negedge clk);
        chk("s3_mac_low", mac_val, 0);
        chk("s3_cmd_rdy_in_mac", cmd_rdy, 0);
        tick(); tick();
        cmd_val = 0;
        chk("s3_mac_cycles", mac_hi, 5);
        @(negedge clk) chk("s3_not_busy", busy, 0);
        ctrl_state = 0; tick();

        // zero-length LOAD_X
        clear_logs();
        issue(0, 0, 0);
        in_val = 1; in_data = 8'hEE;
        @(negedge clk);
        chk("s4_busy", busy, 1);
        chk("s4_in_rdy", in_rdy, 0);
        tick(); in_val = 0;
        @(negedge clk);
        chk("s4_idle", busy, 0);
        chk("s4_cmd_rdy", cmd_rdy, 1);
        tick();
        chk("s4_no_strobe", x_log.size(), 0);

        // reset after two of four words
        clear_logs();
        issue(0, 0, 4);
        in_val = 1; in_data = 8'h01; tick();
        in_data = 8'h02; tick();
        rst = 1; in_data = 8'h03; tick();
        rst = 0; in_val = 0;
        @(negedge clk);
        chk("s5_x", x_load_val, 0);
        chk("s5_w", w_load_val, 0);
        chk("s5_in_rdy", in_rdy, 0);
        chk("s5_busy", busy, 0);
        chk("s5_data", load_data, 0);
        tick();
        issue(0, 0, 1);
        in_val = 1; in_data = 8'h5A; tick();
        in_val = 0; tick(); tick();
        chk("s5_count", x_log.size(), 3);
        if (x_log.size() == 3) chk("s5_after", x_log[2], 8'h5A);

        // RUN_OUT from LD1, OUT seen on the third request cycle
        clear_logs(); ctrl_state = 2;
        issue(3, 0, 0);
        tick(); tick();
        ctrl_state = 3; tick();
        cmd_val = 1; cmd_op = 2'd0; cmd_len = 8'd1;
        @(negedge clk);
        chk("s6_cmd_rdy_in_out", cmd_rdy, 0);
        tick(); tick();
        cmd_val = 0;
        chk("s6_out_cycles", out_hi, 3);
        ctrl_state = 0; tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 199) == 0);
            cmd_val    = $urandom_range(0, 1);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_sel    = 2'($urandom_range(0, 3));
            cmd_len    = 8'($urandom_range(0, 5));
            in_val     = ($urandom_range(0, 9) < 7);
            in_data    = 8'($urandom);
            if ($urandom_range(0, 9) == 0) ctrl_state = 2'($urandom_range(0, 3));
            tick();
        end
        rst = 0; cmd_val = 0; in_val = 0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
